ps2_host_ctrl: RTL and testbench

Host-side sequencer for the PS/2 serial transceiver in the IO input-driver path.
- After reset, runs the device init handshake: reset, BAT, enable reporting.
- Then streams received scan/packet bytes into an internal FIFO for the CPU-side MMIO reader.
- Accepts single-byte host commands, with ACK checking, resend retries, timeouts and parity-error recovery.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_rx_fifo.sv | 63 ++++++
 rtl/ps2_host_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_ps2_host_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and PS/2 protocol byte values for the host-side controller.
package ps2_pkg;

    typedef enum logic [2:0] {
        POWERUP,
        SEND,
        WAIT_ACK,
        WAIT_BAT,
        STREAM,
        ERROR
    } state_t;

    // Why the byte in flight was sent; selects how its reply is handled.
    typedef enum logic [1:0] {
        TX_RESET,
        TX_ENABLE,
        TX_CMD,
        TX_RESEND
    } tx_kind_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word fall-through receive FIFO with occupancy count and sticky overflow.
module ps2_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     pop,
    output logic [DW-1:0]            dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          full;
    logic          do_push;
    logic          do_pop;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign count_nxt = count + CW'(do_push) - CW'(do_pop);
    assign dout      = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            if (push && !do_push) overflow <= 1'b1;
            else if (pop)         overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host sequencer: device init handshake, receive streaming into a FIFO,
// and single-byte host commands with ACK/resend/timeout handling.
module ps2_host_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned POWERUP_CYC     = 50_000_000,
    parameter int unsigned ACK_TIMEOUT_CYC = 2_000_000,
    parameter int unsigned BAT_TIMEOUT_CYC = 100_000_000,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [7:0]                    xcvr_tx_data,
    output logic                          xcvr_tx_en,
    input  logic                          xcvr_clk_oe,
    input  logic                          xcvr_tx_complete,
    input  logic [7:0]                    xcvr_rx_data,
    input  logic                          xcvr_rx_valid,
    input  logic                          xcvr_rx_error,
    input  logic [7:0]                    cmd_data,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    output logic                          cmd_done,
    input  logic                          reinit,
    input  logic                          fifo_rd,
    output logic [7:0]                    fifo_dout,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          init_done,
    output logic                          dev_error
);

    localparam int unsigned TMR_W = 32;
    localparam int unsigned RTY_W = 8;

    state_t            state_q, state_d;
    tx_kind_t          kind_q, kind_d;
    logic [TMR_W-1:0]  timer_q, timer_d, timer_inc;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [7:0]        tx_data_d;
    logic              tx_en_d, started_q, started_d;
    logic              reinit_pend_q, reinit_pend_d;
    logic              fe_pend_q, fe_pend_d;
    logic              cmd_ready_d, cmd_done_d, init_done_d, dev_error_d;
    logic              rx_valid_q, clk_oe_q, tx_complete_q;
    logic              rx_rise, rx_ok, rx_bad, clk_oe_rise, tx_complete_rise;
    logic              fifo_push, fifo_flush, start_tx, retry_req, go_init;

    assign rx_rise          = xcvr_rx_valid && !rx_valid_q;
    assign rx_ok            = rx_rise && !xcvr_rx_error;
    assign rx_bad           = rx_rise && xcvr_rx_error;
    assign clk_oe_rise      = xcvr_clk_oe && !clk_oe_q;
    assign tx_complete_rise = xcvr_tx_complete && !tx_complete_q;
    assign timer_inc        = (&timer_q) ? timer_q : timer_q + TMR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= POWERUP;
            kind_q        <= TX_RESET;
            timer_q       <= '0;
            retry_q       <= '0;
            xcvr_tx_data  <= 8'h00;
            xcvr_tx_en    <= 1'b0;
            started_q     <= 1'b0;
            reinit_pend_q <= 1'b0;
            fe_pend_q     <= 1'b0;
            cmd_ready     <= 1'b0;
            cmd_done      <= 1'b0;
            init_done     <= 1'b0;
            dev_error     <= 1'b0;
            rx_valid_q    <= 1'b0;
            clk_oe_q      <= 1'b0;
            tx_complete_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            xcvr_tx_data  <= tx_data_d;
            xcvr_tx_en    <= tx_en_d;
            started_q     <= started_d;
            reinit_pend_q <= reinit_pend_d;
            fe_pend_q     <= fe_pend_d;
            cmd_ready     <= cmd_ready_d;
            cmd_done      <= cmd_done_d;
            init_done     <= init_done_d;
            dev_error     <= dev_error_d;
            rx_valid_q    <= xcvr_rx_valid;
            clk_oe_q      <= xcvr_clk_oe;
            tx_complete_q <= xcvr_tx_complete;
        end
    end

    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        timer_d       = timer_inc;
        retry_d       = retry_q;
        tx_data_d     = xcvr_tx_data;
        tx_en_d       = xcvr_tx_en;
        started_d     = started_q;
        reinit_pend_d = reinit_pend_q;
        fe_pend_d     = fe_pend_q;
        cmd_done_d    = 1'b0;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;
        start_tx      = 1'b0;
        retry_req     = 1'b0;
        go_init       = 1'b0;

        case (state_q)
            POWERUP: begin
                if (timer_q == TMR_W'(POWERUP_CYC)) begin
                    start_tx  = 1'b1;
                    tx_data_d = CMD_RESET;
                    kind_d    = TX_RESET;
                    retry_d   = '0;
                end
            end
            SEND: begin
                if (rx_ok && (kind_q == TX_CMD || kind_q == TX_RESEND)) fifo_push = 1'b1;
                if (reinit) reinit_pend_d = 1'b1;
                if (xcvr_tx_en && clk_oe_rise) begin
                    tx_en_d   = 1'b0;
                    started_d = 1'b1;
                end else if (started_q && tx_complete_rise) begin
                    started_d = 1'b0;
                    if (reinit_pend_q || reinit) begin
                        go_init = 1'b1;
                    end else if (kind_q == TX_RESEND) begin
                        state_d = STREAM;
                    end else begin
                        state_d = WAIT_ACK;
                        timer_d = '0;
                    end
                end
            end
            WAIT_ACK: begin
                if (rx_ok && xcvr_rx_data == RSP_ACK) begin
                    case (kind_q)
                        TX_RESET: begin
                            state_d = WAIT_BAT;
                            timer_d = '0;
                        end
                        TX_ENABLE: state_d = STREAM;
                        default: begin
                            state_d    = STREAM;
                            cmd_done_d = 1'b1;
                        end
                    endcase
                end else if (rx_bad || (rx_ok && xcvr_rx_data == RSP_RESEND) ||
                             timer_q == TMR_W'(ACK_TIMEOUT_CYC)) begin
                    retry_req = 1'b1;
                end
                if (rx_ok && kind_q == TX_CMD && xcvr_rx_data != RSP_ACK &&
                    xcvr_rx_data != RSP_RESEND) fifo_push = 1'b1;
                if (retry_req) begin
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d  = retry_q + RTY_W'(1);
                        start_tx = 1'b1;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            WAIT_BAT: begin
                if (rx_ok && xcvr_rx_data == RSP_BAT_OK) begin
                    start_tx  = 1'b1;
                    tx_data_d = CMD_ENABLE;
                    kind_d    = TX_ENABLE;
                    retry_d   = '0;
                end else if (rx_bad || (rx_ok && xcvr_rx_data == RSP_BAT_FAIL) ||
                             timer_q == TMR_W'(BAT_TIMEOUT_CYC)) begin
                    state_d = ERROR;
                end
            end
            STREAM: begin
                if (rx_ok) fifo_push = 1'b1;
                // An accepted command goes first; a colliding parity error is resent after it.
                if (cmd_valid && cmd_ready) begin
                    start_tx  = 1'b1;
                    tx_data_d = cmd_data;
                    kind_d    = TX_CMD;
                    retry_d   = '0;
                    fe_pend_d = fe_pend_q || rx_bad;
                end else if (rx_bad || fe_pend_q) begin
                    start_tx  = 1'b1;
                    tx_data_d = CMD_RESEND;
                    kind_d    = TX_RESEND;
                    fe_pend_d = 1'b0;
                end
            end
            ERROR: ;
            default: state_d = POWERUP;
        endcase

        if (start_tx) begin
            state_d   = SEND;
            tx_en_d   = 1'b1;
            started_d = 1'b0;
        end

        if (reinit && state_q != SEND) go_init = 1'b1;

        // Preset the power-up counter so the reset command goes out immediately.
        if (go_init) begin
            state_d       = POWERUP;
            timer_d       = TMR_W'(POWERUP_CYC);
            fifo_flush    = 1'b1;
            tx_en_d       = 1'b0;
            started_d     = 1'b0;
            reinit_pend_d = 1'b0;
            fe_pend_d     = 1'b0;
            cmd_done_d    = 1'b0;
        end

        cmd_ready_d = (state_d == STREAM) && !fe_pend_d;
        init_done_d = (state_d == STREAM) ||
                      ((state_d == SEND || state_d == WAIT_ACK) &&
                       (kind_d == TX_CMD || kind_d == TX_RESEND));
        dev_error_d = (state_d == ERROR);
    end

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (8)
    ) u_rx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (fifo_flush),
        .push     (fifo_push),
        .din      (xcvr_rx_data),
        .pop      (fifo_rd),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed/randomized bench for ps2_host_ctrl with a queue-based FIFO reference model.
module tb_ps2_host_ctrl;

    localparam int P_PWR   = 10;
    localparam int P_ACK   = 100;
    localparam int P_BAT   = 300;
    localparam int P_RTY   = 3;
    localparam int P_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] xcvr_tx_data;
    logic       xcvr_tx_en;
    logic       xcvr_clk_oe;
    logic       xcvr_tx_complete;
    logic [7:0] xcvr_rx_data;
    logic       xcvr_rx_valid;
    logic       xcvr_rx_error;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_done;
    logic       reinit;
    logic       fifo_rd;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       init_done;
    logic       dev_error;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] mq [$];
    logic       m_ovf = 1'b0;

    ps2_host_ctrl #(
        .POWERUP_CYC     (P_PWR),
        .ACK_TIMEOUT_CYC (P_ACK),
        .BAT_TIMEOUT_CYC (P_BAT),
        .MAX_RETRY       (P_RTY),
        .FIFO_DEPTH      (P_DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .xcvr_tx_data     (xcvr_tx_data),
        .xcvr_tx_en       (xcvr_tx_en),
        .xcvr_clk_oe      (xcvr_clk_oe),
        .xcvr_tx_complete (xcvr_tx_complete),
        .xcvr_rx_data     (xcvr_rx_data),
        .xcvr_rx_valid    (xcvr_rx_valid),
        .xcvr_rx_error    (xcvr_rx_error),
        .cmd_data         (cmd_data),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_done         (cmd_done),
        .reinit           (reinit),
        .fifo_rd          (fifo_rd),
        .fifo_dout        (fifo_dout),
        .fifo_empty       (fifo_empty),
        .fifo_count       (fifo_count),
        .overflow         (overflow),
        .init_done        (init_done),
        .dev_error        (dev_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference FIFO: a pop frees space before a same-cycle push; any read clears overflow.
    function automatic void model_step(input logic push, input logic [7:0] b, input logic pop);
        if (pop) begin
            m_ovf = 1'b0;
            if (mq.size() > 0) void'(mq.pop_front());
        end
        if (push) begin
            if (mq.size() < P_DEPTH) mq.push_back(b);
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic check_fifo(input string tag);
        check({tag, "_count"}, 32'(fifo_count), 32'(mq.size()));
        check({tag, "_empty"}, 32'(fifo_empty), 32'(mq.size() == 0));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        if (mq.size() > 0) check({tag, "_dout"}, 32'(fifo_dout), 32'(mq[0]));
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic err);
        xcvr_rx_data  = b;
        xcvr_rx_error = err;
        xcvr_rx_valid = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        xcvr_rx_valid = 1'b0;
        xcvr_rx_error = 1'b0;
        tick();
    endtask

    // Acts as the transceiver for one outgoing byte; reports when tx_en was seen and tx_complete edge.
    task automatic expect_send(input logic [7:0] b, input string tag, output int t_en, output int t_comp);
        int n;
        n = 0;
        while (xcvr_tx_en !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        t_en = cyc;
        check({tag, "_en"}, 32'(xcvr_tx_en), 32'd1);
        check({tag, "_data"}, 32'(xcvr_tx_data), 32'(b));
        repeat ($urandom_range(0, 2)) tick();
        check({tag, "_hold"}, 32'(xcvr_tx_en), 32'd1);
        xcvr_clk_oe = 1'b1;
        tick();
        check({tag, "_drop"}, 32'(xcvr_tx_en), 32'd0);
        tick();
        xcvr_clk_oe = 1'b0;
        tick();
        xcvr_tx_complete = 1'b1;
        tick();
        t_comp = cyc;
        tick();
        xcvr_tx_complete = 1'b0;
        tick();
    endtask

    initial begin
        int         t_en, t_comp, prev_comp, n;
        logic [7:0] b;
        logic       seen, do_push, do_pop;
        logic [7:0] sb [5];

        sb = '{8'h1C, 8'hF0, 8'h1C, 8'h32, 8'h33};
        rst_n = 1'b0;
        xcvr_clk_oe = 1'b0;
        xcvr_tx_complete = 1'b0;
        xcvr_rx_data = 8'h00;
        xcvr_rx_valid = 1'b0;
        xcvr_rx_error = 1'b0;
        cmd_data = 8'h00;
        cmd_valid = 1'b0;
        reinit = 1'b0;
        fifo_rd = 1'b0;
        #23;
        check("rst_tx_en", 32'(xcvr_tx_en), 32'd0);
        check("rst_tx_data", 32'(xcvr_tx_data), 32'h00);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_dout", 32'(fifo_dout), 32'h00);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_cmd_done", 32'(cmd_done), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_dev_error", 32'(dev_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Nominal init with noise bytes and two resends of the enable command
        expect_send(8'hFF, "init_ff", t_en, t_comp);
        rx_byte(8'($urandom_range(1, 127)), 1'b0);
        rx_byte(8'hFA, 1'b0);
        check("bat_init_done", 32'(init_done), 32'd0);
        rx_byte(8'($urandom_range(1, 127)), 1'b0);
        rx_byte(8'hAA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_send(8'hF4, "init_f4", t_en, t_comp);
            if (i < 2) rx_byte(8'hFE, 1'b0);
        end
        rx_byte(8'hFA, 1'b0);
        check("init_done", 32'(init_done), 32'd1);
        check("init_cmd_ready", 32'(cmd_ready), 32'd1);
        check("init_dev_error", 32'(dev_error), 32'd0);
        check_fifo("init_fifo");

        // Overflow on a full FIFO, then a read clears it
        foreach (sb[i]) begin
            rx_byte(sb[i], 1'b0);
            model_step(1'b1, sb[i], 1'b0);
        end
        check_fifo("ovf");
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        model_step(1'b0, 8'h00, 1'b1);
        check_fifo("ovf_rd");

        // Random push/pop traffic in STREAM
        for (int i = 0; i < 32; i++) begin
            do_push = ($urandom_range(0, 3) != 0);
            do_pop  = 1'($urandom_range(0, 1));
            b = 8'($urandom);
            xcvr_rx_data  = b;
            xcvr_rx_valid = do_push;
            fifo_rd       = do_pop;
            tick();
            xcvr_rx_valid = 1'b0;
            fifo_rd       = 1'b0;
            model_step(do_push, b, do_pop);
            check_fifo("rnd");
            tick();
        end

        // Parity error in STREAM: not pushed, one FE sent, no ACK awaited
        rx_byte(8'($urandom), 1'b1);
        check("par_cmd_ready_lo", 32'(cmd_ready), 32'd0);
        expect_send(8'hFE, "par_fe", t_en, t_comp);
        check("par_cmd_ready", 32'(cmd_ready), 32'd1);
        check("par_init_done", 32'(init_done), 32'd1);
        check_fifo("par_fifo");
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (xcvr_tx_en) seen = 1'b1;
        end
        check("par_once", 32'(seen), 32'd0);

        // Host command with an unrelated byte arriving before the ACK
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        cmd_data  = 8'hED;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("cmd_ready_drop", 32'(cmd_ready), 32'd0);
        check("cmd_init_done", 32'(init_done), 32'd1);
        expect_send(8'hED, "cmd_ed", t_en, t_comp);
        rx_byte(8'h12, 1'b0);
        model_step(1'b1, 8'h12, 1'b0);
        check_fifo("cmd_rx");
        xcvr_rx_data  = 8'hFA;
        xcvr_rx_valid = 1'b1;
        tick();
        check("cmd_done_pulse", 32'(cmd_done), 32'd1);
        tick();
        check("cmd_done_end", 32'(cmd_done), 32'd0);
        xcvr_rx_valid = 1'b0;
        tick();
        check("cmd_ready_back", 32'(cmd_ready), 32'd1);
        check_fifo("cmd_fifo");

        n = 0;
        while (mq.size() > 0 && n < 10) begin
            fifo_rd = 1'b1;
            tick();
            fifo_rd = 1'b0;
            model_step(1'b0, 8'h00, 1'b1);
            check_fifo("drain");
            n++;
        end

        // reinit from STREAM flushes the FIFO and sends FF at once
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            rx_byte(b, 1'b0);
            model_step(1'b1, b, 1'b0);
        end
        check_fifo("pre_flush");
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        check_fifo("flush");
        check("flush_init_done", 32'(init_done), 32'd0);
        tick();
        check("reinit_en", 32'(xcvr_tx_en), 32'd1);
        check("reinit_data", 32'(xcvr_tx_data), 32'hFF);

        // ACK timeout: four sends spaced by at least the timeout, then ERROR
        prev_comp = 0;
        for (int i = 0; i < 4; i++) begin
            expect_send(8'hFF, "to_ff", t_en, t_comp);
            if (i > 0) check("to_gap", 32'((t_en - prev_comp) >= P_ACK), 32'd1);
            prev_comp = t_comp;
        end
        n = 0;
        while (!dev_error && n < 300) begin
            tick();
            n++;
        end
        check("to_dev_error", 32'(dev_error), 32'd1);
        check("to_err_gap", 32'((cyc - prev_comp) >= P_ACK), 32'd1);
        check("to_tx_idle", 32'(xcvr_tx_en), 32'd0);
        check("to_init_done", 32'(init_done), 32'd0);

        // reinit from ERROR
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        check("err_reinit_clr", 32'(dev_error), 32'd0);
        tick();
        check("err_reinit_en", 32'(xcvr_tx_en), 32'd1);
        check("err_reinit_data", 32'(xcvr_tx_data), 32'hFF);

        // reinit during a send is held until tx_complete
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        check("latch_hold", 32'(xcvr_tx_en), 32'd1);
        xcvr_clk_oe = 1'b1;
        tick();
        check("latch_drop", 32'(xcvr_tx_en), 32'd0);
        xcvr_clk_oe = 1'b0;
        tick();
        xcvr_tx_complete = 1'b1;
        tick();
        xcvr_tx_complete = 1'b0;
        tick();
        check("latch_resend_en", 32'(xcvr_tx_en), 32'd1);
        check("latch_resend_data", 32'(xcvr_tx_data), 32'hFF);

        // Four resend requests for F4 exhaust the retries
        expect_send(8'hFF, "x4_ff", t_en, t_comp);
        rx_byte(8'hFA, 1'b0);
        rx_byte(8'hAA, 1'b0);
        for (int i = 0; i < 4; i++) begin
            expect_send(8'hF4, "x4_f4", t_en, t_comp);
            rx_byte(8'hFE, 1'b0);
            if (i == 2) check("x4_no_err_yet", 32'(dev_error), 32'd0);
        end
        check("x4_dev_error", 32'(dev_error), 32'd1);
        check("x4_tx_idle", 32'(xcvr_tx_en), 32'd0);
        check("x4_init_done", 32'(init_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
